// File: rtl/vid_timing_gen.sv
// Video timing generator: raster counters, HS/VS/DE, and an RGB555 stream consumer
// that locks the stream's frame start to the raster origin and expands pixels to RGB888.
module vid_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic [14:0] iST_DATA,
  input  logic        iST_DV,
  input  logic        iST_START,
  output logic        oST_READY,
  output logic [7:0]  oRED,
  output logic [7:0]  oGRN,
  output logic [7:0]  oBLU,
  output logic        oHS,
  output logic        oVS,
  output logic        oDE,
  output logic        oFRAME,
  output logic        oUNDERRUN
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] S_SYNC_WAIT = 1'b0;
  localparam logic [0:0] S_RUN       = 1'b1;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [0:0]    state_q, state_d;
  logic [7:0]    red_q, grn_q, blu_q;
  logic          hs_q, vs_q, de_q, frame_q, under_q;

  logic origin_c, active_c, hs_act_c, vs_act_c;
  logic ready_c, show_c, under_c;

  assign origin_c = (h_q == '0) && (v_q == '0);
  assign active_c = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_act_c = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_act_c = (v_q >= VS_START) && (v_q < VS_END);

  // Raster advance, lock FSM and stream handshake
  always_comb begin
    h_d     = (h_q == H_LAST) ? '0 : h_q + HW'(1);
    v_d     = v_q;
    state_d = state_q;
    ready_c = 1'b0;
    show_c  = 1'b0;
    under_c = 1'b0;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
    case (state_q)
      S_SYNC_WAIT: begin
        // Non-start pixels are drained; a start pixel waits for the origin
        ready_c = iST_START ? origin_c : 1'b1;
        if (iST_DV && iST_START && origin_c) begin
          show_c  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ready_c = active_c && !(iST_START && !origin_c);
        if (active_c && !iST_DV) begin
          under_c = 1'b1;
          state_d = S_SYNC_WAIT;
        end else if (iST_DV && iST_START && !origin_c) begin
          state_d = S_SYNC_WAIT;
        end else if (active_c) begin
          show_c = 1'b1;
        end
      end
      default: state_d = S_SYNC_WAIT;
    endcase
    if (!iRESETn) begin
      ready_c = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      h_q     <= '0;
      v_q     <= '0;
      state_q <= S_SYNC_WAIT;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      state_q <= state_d;
      red_q   <= show_c ? {iST_DATA[14:10], iST_DATA[14:12]} : 8'h00;
      grn_q   <= show_c ? {iST_DATA[9:5],   iST_DATA[9:7]}   : 8'h00;
      blu_q   <= show_c ? {iST_DATA[4:0],   iST_DATA[4:2]}   : 8'h00;
      hs_q    <= hs_act_c ? HS_POL : ~HS_POL;
      vs_q    <= vs_act_c ? VS_POL : ~VS_POL;
      de_q    <= active_c;
      frame_q <= origin_c;
      under_q <= under_c;
    end
  end

  assign oST_READY = ready_c;
  assign oRED      = red_q;
  assign oGRN      = grn_q;
  assign oBLU      = blu_q;
  assign oHS       = hs_q;
  assign oVS       = vs_q;
  assign oDE       = de_q;
  assign oFRAME    = frame_q;
  assign oUNDERRUN = under_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen on a tiny 8x6 raster: directed scenarios plus a random
// stream phase, all checked against a slot-index reference model.
module tb_vid_timing_gen;

  localparam int HA = 4, HF = 1, HSY = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam int PIX_PER_FRAME = HA * VA;

  logic        clk = 1'b0;
  logic        rst_n, dv, st;
  logic [14:0] data;
  logic        ready;
  logic [7:0]  red, grn, blu;
  logic        hs, vs, de, frame, under;

  always #5 clk = ~clk;

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .iCLK(clk), .iRESETn(rst_n), .iST_DATA(data), .iST_DV(dv), .iST_START(st),
    .oST_READY(ready), .oRED(red), .oGRN(grn), .oBLU(blu), .oHS(hs), .oVS(vs),
    .oDE(de), .oFRAME(frame), .oUNDERRUN(under)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: raster slot index within the frame plus a locked flag
  int       pos = 0;
  bit       locked = 0;
  bit       out_valid = 0;
  logic [7:0] e_r, e_g, e_b;
  logic     e_hs, e_vs, e_de, e_fr, e_un;

  // Stream source: pixel index within its frame, current held pixel
  int          pix_idx = 0;
  logic [14:0] src_data = 15'h4210;
  bit          rand_mode = 0;

  function automatic logic [7:0] x8(input logic [4:0] c);
    return 8'(int'(c) * 8 + int'(c) / 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: check previous slot's outputs, drive inputs, check ready, advance model
  task automatic step(input logic r, input logic v, input logic s, input logic [14:0] d,
                      output bit acc);
    int h, vv;
    bit origin, act, e_rdy, show, und;
    if (out_valid) begin
      chk("red", red, e_r);   chk("grn", grn, e_g);   chk("blu", blu, e_b);
      chk("hs", hs, e_hs);    chk("vs", vs, e_vs);    chk("de", de, e_de);
      chk("frame", frame, e_fr); chk("underrun", under, e_un);
    end
    rst_n = r; dv = v; st = s; data = d;
    #1;
    h = pos % HT; vv = pos / HT;
    origin = (pos == 0);
    act = (h < HA) && (vv < VA);
    show = 0; und = 0;
    if (!r) begin
      e_rdy = 0;
      e_r = 0; e_g = 0; e_b = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_fr = 0; e_un = 0;
      pos = 0; locked = 0;
    end else begin
      if (!locked) begin
        e_rdy = s ? origin : 1'b1;
        if (v && s && origin) begin show = 1; locked = 1; end
      end else begin
        e_rdy = act && !(s && !origin);
        if (act && !v) begin und = 1; locked = 0; end
        else if (v && s && !origin) locked = 0;
        else if (act) show = 1;
      end
      e_r  = show ? x8(d[14:10]) : 8'h00;
      e_g  = show ? x8(d[9:5])   : 8'h00;
      e_b  = show ? x8(d[4:0])   : 8'h00;
      e_hs = !(h >= HA + HF && h < HA + HF + HSY);
      e_vs = !(vv >= VA + VF && vv < VA + VF + VSY);
      e_de = act; e_fr = origin; e_un = und;
      pos  = (pos + 1) % FT;
    end
    chk("ready", ready, e_rdy);
    acc = e_rdy && v;
    out_valid = 1;
    @(negedge clk);
  endtask

  task automatic src_step(input bit f_dv0, input bit f_st, input logic r, output bit acc);
    if (f_st) pix_idx = 0;
    step(r, !f_dv0, pix_idx == 0, src_data, acc);
    if (acc) begin
      pix_idx  = (pix_idx + 1) % PIX_PER_FRAME;
      src_data = rand_mode ? 15'($urandom) : 15'h4210;
    end
  endtask

  task automatic adv_to(input int target);
    int k;
    bit acc;
    k = 0;
    while (pos != target && k < 200) begin
      src_step(0, 0, 1'b1, acc);
      k++;
    end
    chk("advance_timeout", 32'(pos), 32'(target));
  endtask

  initial begin
    bit acc;
    int k, cnt_hs, cnt_vs, cnt_de, cnt_84, cnt_un;
    rst_n = 0; dv = 0; st = 0; data = '0;
    @(negedge clk);

    // Reset
    step(0, 0, 0, '0, acc);
    step(0, 0, 0, '0, acc);
    chk("rst_de", de, 0); chk("rst_hs", hs, 1); chk("rst_vs", vs, 1);
    chk("rst_red", red, 0); chk("rst_frame", frame, 0);

    // Scenario 1: free-running raster, no data
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
    for (int i = 0; i < FT + 1; i++) begin
      if (i > 0) begin
        cnt_hs += (hs == 1'b0) ? 1 : 0;
        cnt_vs += (vs == 1'b0) ? 1 : 0;
        cnt_de += (de == 1'b1) ? 1 : 0;
      end
      step(1, 0, 0, '0, acc);
    end
    chk("s1_hs_low", 32'(cnt_hs), 32'(HSY * VT));
    chk("s1_vs_low", 32'(cnt_vs), 32'(VSY * HT));
    chk("s1_de_cnt", 32'(cnt_de), 32'(HA * VA));

    // Scenario 2: start pixel presented mid-frame, held until origin
    for (int i = 0; i < 20; i++) step(1, 0, 0, '0, acc);
    pix_idx = 0; src_data = 15'h7C00;
    k = 0; acc = 0;
    while (!acc && k < 100) begin src_step(0, 0, 1'b1, acc); k++; end
    chk("s2_lock_timeout", 32'(acc), 1);
    chk("s2_frame", frame, 1); chk("s2_de", de, 1);
    chk("s2_red", red, 8'hFF); chk("s2_grn", grn, 0); chk("s2_blu", blu, 0);

    // Scenario 3: locked stream for two frames
    cnt_de = 0; cnt_84 = 0; cnt_un = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      cnt_de += de ? 1 : 0;
      cnt_84 += (de && red == 8'h84 && grn == 8'h84 && blu == 8'h84) ? 1 : 0;
      cnt_un += under ? 1 : 0;
      src_step(0, 0, 1'b1, acc);
    end
    chk("s3_de_cnt", 32'(cnt_de), 32'(2 * HA * VA));
    chk("s3_rgb84_cnt", 32'(cnt_84), 32'(2 * HA * VA - 1));
    chk("s3_underrun_cnt", 32'(cnt_un), 0);

    // Scenario 4: underrun at (2,1), then relock at origin
    adv_to(1 * HT + 2);
    chk("s4_locked", 32'(locked), 1);
    src_step(1, 0, 1'b1, acc);
    chk("s4_underrun", under, 1); chk("s4_black", red, 0);
    adv_to(0);
    src_step(0, 0, 1'b1, acc);
    chk("s4_relock_frame", frame, 1); chk("s4_relock_red", red, 8'h84);

    // Scenario 5: unexpected start at (1,2)
    adv_to(2 * HT + 1);
    src_step(0, 1, 1'b1, acc);
    chk("s5_not_accepted", 32'(acc), 0);
    chk("s5_black", red, 0); chk("s5_de", de, 1);
    adv_to(0);
    src_step(0, 0, 1'b1, acc);
    chk("s5_held_accepted", 32'(acc), 1);
    chk("s5_frame", frame, 1); chk("s5_red", red, 8'h84);

    // Scenario 6: reset at (3,1) while locked
    adv_to(1 * HT + 3);
    src_step(0, 0, 1'b0, acc);
    chk("s6_de", de, 0); chk("s6_red", red, 0); chk("s6_hs", hs, 1); chk("s6_vs", vs, 1);
    pix_idx = 0;
    k = 0; acc = 0;
    while (!acc && k < 100) begin src_step(0, 0, 1'b1, acc); k++; end
    chk("s6_relock_timeout", 32'(acc), 1);
    chk("s6_frame", frame, 1); chk("s6_red", red, 8'h84);

    // Random stream: random data, occasional dropouts and stray starts
    rand_mode = 1;
    for (int i = 0; i < 6 * FT; i++) begin
      src_step($urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, 1'b1, acc);
    end
    step(1, 0, 0, '0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
